tick_period_meter: RTL and testbench

// Measures the interval, in clock cycles, between successive tick strobes, e.g. the
// out_signal of a rate divider or a debounced drum-hit pulse. It converts a pulse train

---
 rtl/tick_period_meter.sv | 125 ++++++++++++
 tb/tb_tick_period_meter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_period_meter.sv
// Tick-to-tick interval meter: counts clock cycles between rising edges of tick_in and
// presents each accepted interval on a valid/ready register, with timeout and overrun flags.
module tick_period_meter #(
  parameter int WIDTH      = 28,
  parameter int MIN_PERIOD = 1,
  parameter int MAX_PERIOD = 200000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             overrun,
  output logic             measuring
);

  typedef enum logic {S_IDLE, S_MEASURE} state_t;

  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_PERIOD);
  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic             r_tick_q;
  logic             w_tick_ev;
  logic             w_capture;
  logic             w_expire;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;
  logic             r_overrun;

  assign w_tick_ev = tick_in & ~r_tick_q;

  // State and counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tick_q <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_tick_q <= tick_in;
    end
  end

  // Next state; the counter never passes MAX_PERIOD, so it cannot wrap
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_expire     = 1'b0;
    if (!enable) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_next = '0;
          if (w_tick_ev) begin
            w_cnt_next   = L_ONE;
            w_state_next = S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (w_tick_ev && (r_cnt >= L_MIN)) begin
            w_capture  = 1'b1;
            w_cnt_next = L_ONE;
          end else if (r_cnt >= L_MAX) begin
            w_expire     = 1'b1;
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
          end else begin
            w_cnt_next = r_cnt + L_ONE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    measuring = (r_state == S_MEASURE);
  end

  // Result register: a capture into a stalled, still-full register is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_capture) begin
        if (!r_valid || period_ready) begin
          r_period  <= r_cnt;
          r_valid   <= 1'b1;
          r_timeout <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else begin
        if (r_valid && period_ready) r_valid <= 1'b0;
        if (w_expire) r_timeout <= 1'b1;
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: directed scenarios plus random traffic, each cycle checked
// against a timestamp-based reference model.
module tb_tick_period_meter;

  localparam int W    = 28;
  localparam int MINP = 4;
  localparam int MAXP = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         tick = 1'b0;
  logic         rdy = 1'b0;
  logic [W-1:0] o_period;
  logic         o_valid;
  logic         o_timeout;
  logic         o_overrun;
  logic         o_meas;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tick_period_meter #(.WIDTH(W), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)) dut (
    .clock(clk), .reset(rst), .enable(en), .tick_in(tick),
    .period(o_period), .period_valid(o_valid), .period_ready(rdy),
    .timeout(o_timeout), .overrun(o_overrun), .measuring(o_meas)
  );

  // Reference model: remembers when the current interval started and measures elapsed time
  logic [W-1:0] m_period = '0;
  logic         m_valid = 1'b0, m_timeout = 1'b0, m_overrun = 1'b0, m_active = 1'b0;
  logic         m_prev = 1'b0;
  longint       m_n = 0, m_start = 0;
  logic [W+3:0] w_obs, m_exp;
  assign w_obs = {o_period, o_valid, o_timeout, o_overrun, o_meas};
  assign m_exp = {m_period, m_valid, m_timeout, m_overrun, m_active};

  always @(posedge clk) begin
    logic         ev, cap, expire;
    longint       el;
    logic [W-1:0] cv;
    m_n = m_n + 1;
    if (rst) begin
      m_prev = 0; m_active = 0; m_period = '0; m_valid = 0; m_timeout = 0; m_overrun = 0;
    end else begin
      ev = tick && !m_prev;
      m_prev = tick;
      cap = 0; expire = 0; cv = '0;
      if (!en) m_active = 0;
      else if (m_active) begin
        el = m_n - m_start;
        if (ev && el >= MINP) begin
          cap = 1; cv = W'(el); m_start = m_n;
        end else if (el >= MAXP) begin
          expire = 1; m_active = 0;
        end
      end else if (ev) begin
        m_active = 1; m_start = m_n;
      end
      m_overrun = 0;
      if (cap) begin
        if (!m_valid || rdy) begin
          m_period = cv; m_valid = 1; m_timeout = 0;
        end else m_overrun = 1;
      end else if (m_valid && rdy) m_valid = 0;
      if (expire) m_timeout = 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; en = 1'b1; rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rdy = 1'b1; tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (w_obs !== '0) begin n_bad++; $display("FAIL reset_state got %h want 0", w_obs); end
    rst = 1'b0; tick = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_meas !== 1'b1) begin n_bad++; $display("FAIL first_cycle_tick measuring got %b want 1", o_meas); end
    n_cmp++;
    if (w_obs !== m_exp) begin n_bad++; $display("FAIL model[reset] got %h want %h", w_obs, m_exp); end
    tick = 1'b0;
  endtask

  task automatic test_rate_divider();
    do_reset();
    for (int c = 0; c < 31; c++) begin
      tick = (c % 5 == 0);
      @(negedge clk);
      n_cmp++;
      if (w_obs !== m_exp) begin n_bad++; $display("FAIL model[divider c=%0d] got %h want %h", c, w_obs, m_exp); end
      n_cmp++;
      if (c > 0 && c % 5 == 0) begin
        if (o_valid !== 1'b1 || o_period !== 28'd5) begin
          n_bad++; $display("FAIL divider_result c=%0d got v=%b p=%0d want v=1 p=5", c, o_valid, o_period);
        end
      end else if (o_valid !== 1'b0) begin
        n_bad++; $display("FAIL divider_idle c=%0d got v=%b want 0", c, o_valid);
      end
    end
  endtask

  task automatic test_min_period();
    do_reset();
    for (int c = 0; c < 25; c++) begin
      tick = (c == 10) || (c == 13) || (c == 20);
      @(negedge clk);
      n_cmp++;
      if (w_obs !== m_exp) begin n_bad++; $display("FAIL model[minp c=%0d] got %h want %h", c, w_obs, m_exp); end
      n_cmp++;
      if (o_valid !== (c == 20) || o_overrun !== 1'b0 || (c == 20 && o_period !== 28'd10)) begin
        n_bad++; $display("FAIL min_period c=%0d got v=%b ov=%b p=%0d want v=%b ov=0 p=10", c, o_valid, o_overrun, o_period, c == 20);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      tick = (c == 0) || (c == 5) || (c == 10);
      rdy = (c >= 12);
      @(negedge clk);
      n_cmp++;
      if (w_obs !== m_exp) begin n_bad++; $display("FAIL model[overrun c=%0d] got %h want %h", c, w_obs, m_exp); end
      if (c >= 5) begin
        n_cmp++;
        if (o_overrun !== (c == 10) || o_valid !== (c < 12) || o_period !== 28'd5) begin
          n_bad++; $display("FAIL overrun c=%0d got ov=%b v=%b p=%0d want ov=%b v=%b p=5", c, o_overrun, o_valid, o_period, c == 10, c < 12);
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 120; c++) begin
      tick = (c == 0) || (c == 110) || (c == 117);
      @(negedge clk);
      n_cmp++;
      if (w_obs !== m_exp) begin n_bad++; $display("FAIL model[timeout c=%0d] got %h want %h", c, w_obs, m_exp); end
      if (c == 99 || c == 100 || c == 116 || c == 117) begin
        n_cmp++;
        if (o_timeout !== (c == 100 || c == 116) || o_meas !== (c != 100) || (c == 117 && (o_valid !== 1'b1 || o_period !== 28'd7))) begin
          n_bad++; $display("FAIL timeout c=%0d got to=%b m=%b v=%b p=%0d", c, o_timeout, o_meas, o_valid, o_period);
        end
      end
    end
  endtask

  task automatic test_level_hold();
    do_reset();
    for (int c = 0; c < 64; c++) begin
      logic         want_v;
      logic [W-1:0] want_p;
      tick = (c < 8) || (c == 9) || (c >= 30 && c < 50) || (c == 60);
      @(negedge clk);
      n_cmp++;
      if (w_obs !== m_exp) begin n_bad++; $display("FAIL model[level c=%0d] got %h want %h", c, w_obs, m_exp); end
      want_v = (c == 9) || (c == 30) || (c == 60);
      want_p = (c == 9) ? 28'd9 : (c == 30) ? 28'd21 : 28'd30;
      n_cmp++;
      if (o_valid !== want_v || (want_v && o_period !== want_p)) begin
        n_bad++; $display("FAIL level_hold c=%0d got v=%b p=%0d want v=%b p=%0d", c, o_valid, o_period, want_v, want_p);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy = 1'b0;
    for (int c = 0; c < 18; c++) begin
      tick = (c == 0) || (c == 5) || (c == 10) || (c == 16);
      rst = (c == 8);
      rdy = (c >= 9);
      @(negedge clk);
      n_cmp++;
      if (w_obs !== m_exp) begin n_bad++; $display("FAIL model[rstmid c=%0d] got %h want %h", c, w_obs, m_exp); end
      if (c == 7) begin
        n_cmp++;
        if (o_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got v=%b want 1", o_valid); end
      end else if (c == 8) begin
        n_cmp++;
        if (w_obs !== '0) begin n_bad++; $display("FAIL rstmid_clear got %h want 0", w_obs); end
      end else if (c > 8) begin
        n_cmp++;
        if (o_valid !== (c == 16) || (c == 16 && o_period !== 28'd6)) begin
          n_bad++; $display("FAIL rstmid_after c=%0d got v=%b p=%0d want v=%b p=6", c, o_valid, o_period, c == 16);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic silent;
      silent = (c % 600) > 470;
      tick = silent ? 1'b0 : ($urandom_range(0, 4) == 0);
      en   = ($urandom_range(0, 40) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      rst  = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      n_cmp++;
      if (w_obs !== m_exp) begin n_bad++; $display("FAIL model[random c=%0d] got %h want %h", c, w_obs, m_exp); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rate_divider();
    test_min_period();
    test_overrun();
    test_timeout();
    test_level_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
